// File: rtl/alu_mult_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// ALU command codes and the multiplier controller state encoding.
package alu_mult_seq_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_XOR  = 3'd2,
    ALU_SLT  = 3'd3,
    ALU_AND  = 3'd4,
    ALU_NAND = 3'd5,
    ALU_NOR  = 3'd6,
    ALU_OR   = 3'd7
  } alu_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

endpackage

// File: rtl/alu_mult_seq_if.sv
// Bundle of the multiplier's request/result signals and its borrowed-ALU handshake.
// The slave modport is the multiplier; master is the CPU control/datapath side.
interface alu_mult_seq_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic                 alu_req;
  logic                 alu_gnt;
  logic [WIDTH-1:0]     alu_a;
  logic [WIDTH-1:0]     alu_b;
  logic [2:0]           alu_command;
  logic [WIDTH-1:0]     alu_sum;
  logic                 alu_carryout;

  modport master (
    output start, op_a, op_b, alu_gnt, alu_sum, alu_carryout,
    input  busy, done, product, alu_req, alu_a, alu_b, alu_command
  );

  modport slave (
    input  start, op_a, op_b, alu_gnt, alu_sum, alu_carryout,
    output busy, done, product, alu_req, alu_a, alu_b, alu_command
  );
endinterface

// File: rtl/alu_mult_seq.sv
// Iterative unsigned WIDTH x WIDTH shift-add multiplier that borrows the shared
// ALU adder one granted cycle per iteration; ungranted cycles simply stall.
module alu_mult_seq
  import alu_mult_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  alu_mult_seq_if.slave    bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  mult_state_e       state_q, state_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  p_hi_q,  p_hi_d;
  logic [WIDTH-1:0]  p_lo_q,  p_lo_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              req_q,   req_d;
  logic [WIDTH-1:0]  alu_a_q, alu_a_d;
  logic [WIDTH-1:0]  alu_b_q, alu_b_d;

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mcand_d = bus.op_a;
          p_lo_d  = bus.op_b;
          p_hi_d  = '0;
          count_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Carry joins the sum so the 33-bit result shifts right without loss.
        if (bus.alu_gnt) begin
          p_hi_d  = {bus.alu_carryout, bus.alu_sum[WIDTH-1:1]};
          p_lo_d  = {bus.alu_sum[0], p_lo_q[WIDTH-1:1]};
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so the ALU operands are
    // already in place for the cycle in which they are consumed.
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    req_d   = (state_d == ST_RUN);
    alu_a_d = req_d ? p_hi_d : '0;
    alu_b_d = (req_d && p_lo_d[0]) ? mcand_d : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mcand_q <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      alu_a_q <= '0;
      alu_b_q <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.alu_req     = req_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_command = ALU_ADD;
  assign bus.product     = {p_hi_q, p_lo_q};

endmodule
